paramest_nn_mac_seq: RTL



---
 rtl/paramest_nn_mac_seq.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/paramest_nn_mac_seq.sv
// Time-multiplexed MAC sequencer for one dense ParamEst layer.
// One shared external multiplier, 3-stage read/multiply/accumulate pipe.
module paramest_nn_mac_seq #(
  parameter  int N_IN        = 5,
  parameter  int N_OUT       = 8,
  parameter  int ACC_WIDTH   = 32,
  parameter  int WADDR_WIDTH = 6,
  localparam int OW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
  localparam int KW = (N_IN > 1) ? $clog2(N_IN) : 1
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  input  logic [15:0]            in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [WADDR_WIDTH-1:0] w_addr,
  output logic                   w_rd_en,
  input  logic [9:0]             w_data,
  output logic [OW-1:0]          b_addr,
  input  logic [ACC_WIDTH-1:0]   b_data,
  output logic [15:0]            mul_a,
  output logic [9:0]             mul_b,
  input  logic [25:0]            mul_p,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic [OW-1:0]          out_idx,
  output logic                   out_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   busy
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_MAC,
    S_EMIT
  } state_t;

  state_t                 state_q, state_d;
  logic [KW-1:0]          k_q, k_d;
  logic [KW-1:0]          i_q, i_d;
  logic [OW-1:0]          o_q, o_d;
  logic                   rd_q, rd_d;
  logic [WADDR_WIDTH-1:0] addr_q, addr_d;
  logic                   vb_q, vb_d;
  logic [KW-1:0]          ib_q, ib_d;
  logic                   vc_q, vc_d;
  logic [25:0]            p_q, p_d;
  logic [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [15:0]            x_q [N_IN];
  logic [15:0]            x_d [N_IN];

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    o_d     = o_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    vb_d    = 1'b0;
    ib_d    = ib_q;
    vc_d    = vb_q;
    p_d     = p_q;
    acc_d   = acc_q;
    x_d     = x_q;
    unique case (state_q)
      S_LOAD: begin
        if (in_valid) begin
          x_d[k_q] = in_data;
          if (k_q == KW'(N_IN - 1)) begin
            k_d     = '0;
            o_d     = '0;
            i_d     = '0;
            rd_d    = 1'b1;
            addr_d  = '0;
            state_d = S_MAC;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      S_MAC: begin
        if (rd_q) begin
          vb_d   = 1'b1;
          ib_d   = i_q;
          i_d    = i_q + 1'b1;
          addr_d = addr_q + 1'b1;
          if (i_q == KW'(N_IN - 1)) rd_d = 1'b0;
        end
        if (vb_q) p_d = mul_p;
        // Bias enters on the first read cycle, once b_addr shows the new neuron.
        if (rd_q && i_q == '0) acc_d = b_data;
        if (vc_q) begin
          acc_d = acc_q + {{(ACC_WIDTH-26){p_q[25]}}, p_q};
          if (!vb_q) state_d = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          if (o_q == OW'(N_OUT - 1)) begin
            o_d     = '0;
            state_d = S_LOAD;
          end else begin
            o_d     = o_q + 1'b1;
            i_d     = '0;
            rd_d    = 1'b1;
            addr_d  = WADDR_WIDTH'((int'(o_q) + 1) * N_IN);
            state_d = S_MAC;
          end
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q <= S_LOAD;
      k_q     <= '0;
      i_q     <= '0;
      o_q     <= '0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      vb_q    <= 1'b0;
      ib_q    <= '0;
      vc_q    <= 1'b0;
      p_q     <= '0;
      acc_q   <= '0;
      for (int n = 0; n < N_IN; n++) x_q[n] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      o_q     <= o_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      vb_q    <= vb_d;
      ib_q    <= ib_d;
      vc_q    <= vc_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign busy      = !(state_q == S_LOAD && k_q == '0);
  assign w_rd_en   = rd_q;
  assign w_addr    = addr_q;
  assign b_addr    = o_q;
  assign mul_a     = vb_q ? x_q[ib_q] : 16'd0;
  assign mul_b     = vb_q ? w_data : 10'd0;
  assign out_valid = (state_q == S_EMIT);
  assign out_data  = acc_q;
  assign out_idx   = o_q;
  assign out_last  = (state_q == S_EMIT) && (o_q == OW'(N_OUT - 1));

endmodule
